ddr_rd_unpack: RTL

DDR_RD_UNPACK -- requirements
Module: ddr_rd_unpack

---
 rtl/ddr_rd_pkg.sv | 20 ++
 rtl/sync_fifo_64.sv | 86 ++++++++
 rtl/ddr_rd_unpack.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_pkg.sv
// ddr_rd_pkg
//   Shared definitions for the DDR read-and-unpack block: the FSM state
//   encoding, the pixel geometry of one 64-bit DDR word, and the width of the
//   halfword index that walks through a word.
package ddr_rd_pkg;

  // Frame read controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // One 64-bit DDR word carries four 16-bit pixels.
  localparam int PIX_PER_WORD = 4;
  localparam int HW_IDX_W     = 2;
  localparam int PIX_W        = 16;

endpackage : ddr_rd_pkg

// File: rtl/sync_fifo_64.sv
// sync_fifo_64
//   Single-clock FIFO of 2**AW 64-bit words with a registered head word.
//   The head register always holds the oldest stored word once it is valid;
//   pop_i retires that word and the next one is loaded on the same edge.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en_i     : write wr_data_i (ignored when full)
//   wr_data_i   : 64-bit word to store
//   pop_i       : retire the head word (ignored when head_vld_o=0)
//   head_o      : registered oldest word
//   head_vld_o  : head_o holds a stored word
//   level_o     : number of stored words, head word included
module sync_fifo_64
  #(parameter int AW = 4)
  (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [63:0]   wr_data_i,
    input  logic          pop_i,
    output logic [63:0]   head_o,
    output logic          head_vld_o,
    output logic [AW:0]   level_o
  );

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [63:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q, rptr_d;
  logic [63:0] head_q;
  logic        head_vld_q, head_vld_d;
  logic        full_s, empty_s, wr_fire_s, pop_fire_s, head_load_s;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign full_s      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_s     = (wptr_q == rptr_q);
  assign level_o     = wptr_q - rptr_q;
  assign wr_fire_s   = wr_en_i && !full_s;
  assign pop_fire_s  = pop_i && head_vld_q;
  assign head_o      = head_q;
  assign head_vld_o  = head_vld_q;

  // Next read pointer and head-valid; only words written on earlier edges are
  // eligible for the head, so a popped last word leaves a one-cycle gap.
  always_comb begin
    rptr_d     = rptr_q;
    head_vld_d = !empty_s;
    if (pop_fire_s) begin
      rptr_d     = rptr_q + PTR_ONE;
      head_vld_d = (level_o > PTR_ONE);
    end else begin
      rptr_d     = rptr_q;
      head_vld_d = !empty_s;
    end
  end

  assign head_load_s = (pop_fire_s || !head_vld_q) && head_vld_d;

  // Pointer, head word and head-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      head_q     <= 64'd0;
      head_vld_q <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      rptr_q     <= rptr_d;
      head_vld_q <= head_vld_d;
      if (head_load_s) begin
        head_q <= mem_q[rptr_d[AW-1:0]];
      end
    end
  end

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule : sync_fifo_64

// File: rtl/ddr_rd_unpack.sv
// ddr_rd_unpack
//   Reads a frame from DDR in fixed bursts of BURST_LEN 64-bit words and
//   streams it out as 16-bit pixels, low halfword of each word first.
//   Bursts are only requested when the buffer can absorb a whole burst on top
//   of what is already stored or still in flight, so rd_valid never overflows.
// Ports
//   start, base_addr, frame_words : frame command (sampled on start in IDLE)
//   rd_req, rd_addr, rd_ack       : burst request handshake
//   rd_valid, rd_data             : returned DDR words, no back-pressure
//   pix_data, pix_valid, pix_ready: pixel stream with valid/ready handshake
//   busy, done                    : frame in progress / one-cycle completion pulse
module ddr_rd_unpack
  import ddr_rd_pkg::*;
  #(
    parameter int BURST_LEN = 8,
    parameter int BUF_AW    = 4,
    parameter int ADDR_W    = 28
  )
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_words,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [63:0]       rd_data,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
  );

  localparam int OUT_W = $clog2(BURST_LEN) + 1;
  localparam int OCC_W = BUF_AW + 2;
  localparam int CNT_W = ADDR_W + HW_IDX_W;

  state_e              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   frame_words_q, frame_words_d;
  logic [ADDR_W:0]     req_words_q, req_words_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [HW_IDX_W-1:0] hw_idx_q, hw_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_err, ovf_err_d;

  logic [63:0]         head_s;
  logic                head_vld_s;
  logic [BUF_AW:0]     level_s;
  logic [OCC_W-1:0]    occ_s;
  logic                space_ok_s, pix_accept_s, last_hw_s, pop_s, wr_en_s;
  logic                burst_done_s, last_accept_s;

  // Buffer occupancy as seen by the requester: stored words plus words still in flight.
  assign occ_s        = OCC_W'(level_s) + OCC_W'(outst_q) + OCC_W'(BURST_LEN);
  assign space_ok_s   = (occ_s <= OCC_W'(2 ** BUF_AW));
  assign pix_accept_s = head_vld_s && pix_ready;
  assign last_hw_s    = (hw_idx_q == HW_IDX_W'(PIX_PER_WORD - 1));
  assign pop_s        = pix_accept_s && last_hw_s;
  assign wr_en_s      = rd_valid && (state_q != ST_IDLE);
  assign burst_done_s = (outst_q == OUT_W'(0)) || ((outst_q == OUT_W'(1)) && rd_valid);
  assign last_accept_s = pix_accept_s &&
                         (pix_cnt_q == ({frame_words_q, {HW_IDX_W{1'b0}}} - CNT_W'(1)));

  sync_fifo_64 #(.AW(BUF_AW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en_s),
    .wr_data_i  (rd_data),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .head_vld_o (head_vld_s),
    .level_o    (level_s)
  );

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign pix_valid = head_vld_s;
  assign pix_data  = head_s[{hw_idx_q, 4'b0000} +: PIX_W];
  assign busy      = busy_q;
  assign done      = done_q;

  // Halfword walker: steps on every accepted pixel and wraps to 0 with the pop.
  always_comb begin
    hw_idx_d = hw_idx_q;
    if (pix_accept_s) begin
      hw_idx_d = hw_idx_q + HW_IDX_W'(1);
    end else begin
      hw_idx_d = hw_idx_q;
    end
  end

  // Frame FSM next state, request generation and bookkeeping counters.
  always_comb begin
    state_d       = state_q;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    frame_words_d = frame_words_q;
    req_words_d   = req_words_q;
    outst_d       = outst_q;
    pix_cnt_d     = pix_cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ovf_err_d     = ovf_err;

    // Data arriving with no frame in progress is stale and only flagged.
    if (rd_valid && (state_q == ST_IDLE)) begin
      ovf_err_d = 1'b1;
    end else begin
      ovf_err_d = ovf_err;
    end

    if (rd_valid && (outst_q != OUT_W'(0))) begin
      outst_d = outst_q - OUT_W'(1);
    end else begin
      outst_d = outst_q;
    end

    if (pix_accept_s) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end else begin
      pix_cnt_d = pix_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_REQ;
          rd_addr_d     = base_addr;
          frame_words_d = frame_words;
          req_words_d   = '0;
          pix_cnt_d     = '0;
          busy_d        = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (rd_req_q && rd_ack) begin
          rd_req_d    = 1'b0;
          outst_d     = outst_d + OUT_W'(BURST_LEN);
          rd_addr_d   = rd_addr_q + ADDR_W'(BURST_LEN);
          req_words_d = req_words_q + (ADDR_W + 1)'(BURST_LEN);
          state_d     = ST_WAIT;
        end else if (!rd_req_q && space_ok_s) begin
          rd_req_d = 1'b1;
        end else begin
          rd_req_d = rd_req_q;
        end
      end
      ST_WAIT: begin
        if (burst_done_s) begin
          if (req_words_q == {1'b0, frame_words_q}) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (last_accept_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rd_req_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      frame_words_q <= '0;
      req_words_q   <= '0;
      outst_q       <= '0;
      pix_cnt_q     <= '0;
      hw_idx_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      frame_words_q <= frame_words_d;
      req_words_q   <= req_words_d;
      outst_q       <= outst_d;
      pix_cnt_q     <= pix_cnt_d;
      hw_idx_q      <= hw_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ovf_err       <= ovf_err_d;
    end
  end

endmodule : ddr_rd_unpack
